// File: rtl/ahb_mem_arbiter.sv
// Non-preemptive AHB-Lite arbiter: NM masters share one memory slave. The
// address-phase owner keeps the bus until it shows IDLE; round-robin picks the next owner.
module ahb_mem_arbiter #(
  parameter int NM   = 2,
  parameter int PARK = 0
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic [NM*32-1:0] m_haddr,
  input  logic [NM*2-1:0]  m_htrans,
  input  logic [NM-1:0]    m_hwrite,
  input  logic [NM*3-1:0]  m_hsize,
  input  logic [NM*64-1:0] m_hwdata,
  output logic [63:0]      m_hrdata,
  output logic [NM-1:0]    m_hready,
  output logic [NM-1:0]    m_hresp,
  output logic [31:0]      s_haddr,
  output logic [1:0]       s_htrans,
  output logic             s_hwrite,
  output logic [2:0]       s_hsize,
  output logic             s_hsel,
  output logic [63:0]      s_hwdata,
  output logic             s_hready,
  input  logic             s_hreadyout,
  input  logic             s_hresp,
  input  logic [63:0]      s_hrdata
);
  localparam int IW = (NM > 2) ? 2 : 1;
  localparam logic [IW-1:0] PARK_ID = IW'(PARK);

  // Handshake: an address phase is accepted on a rising HCLK where s_hreadyout=1;
  // a master whose m_hready is low must hold its address-phase signals unchanged.
  logic [IW-1:0] own, d_own, rr;
  logic          d_val;
  logic [IW-1:0] own_nxt, d_own_nxt, rr_nxt;
  logic          d_val_nxt;
  logic [IW-1:0] own_cur, d_own_cur, idx;
  logic          d_val_cur, found;
  logic [NM-1:0] req;

  always_comb begin
    req = '0;
    for (int i = 0; i < NM; i++) req[i] = (m_htrans[2*i +: 2] != 2'b00);
  end

  // While reset is low the outputs already behave as if the registers were reset.
  assign own_cur   = HRESETn ? own : PARK_ID;
  assign d_own_cur = HRESETn ? d_own : PARK_ID;
  assign d_val_cur = HRESETn & d_val;

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      own   <= PARK_ID;
      d_own <= PARK_ID;
      d_val <= 1'b0;
      rr    <= PARK_ID;
    end else begin
      own   <= own_nxt;
      d_own <= d_own_nxt;
      d_val <= d_val_nxt;
      rr    <= rr_nxt;
    end
  end

  always_comb begin
    own_nxt   = own;
    d_own_nxt = d_own;
    d_val_nxt = d_val;
    rr_nxt    = rr;
    found     = 1'b0;
    idx       = '0;
    if (s_hreadyout) begin
      d_val_nxt = s_htrans[1];
      d_own_nxt = own;
      if (req[own]) begin
        own_nxt = own;
      end else if (|req) begin
        for (int k = 1; k <= NM; k++) begin
          idx = IW'((int'(rr) + k) % NM);
          if (!found && req[idx]) begin
            found   = 1'b1;
            own_nxt = idx;
            rr_nxt  = idx;
          end
        end
      end else begin
        own_nxt = PARK_ID;
      end
    end
  end

  always_comb begin
    s_haddr  = '0;
    s_htrans = 2'b00;
    s_hwrite = 1'b0;
    s_hsize  = '0;
    s_hwdata = '0;
    m_hready = '0;
    m_hresp  = '0;
    for (int i = 0; i < NM; i++) begin
      if (own_cur == IW'(i)) begin
        s_haddr     = m_haddr[32*i +: 32];
        s_htrans    = m_htrans[2*i +: 2];
        s_hwrite    = m_hwrite[i];
        s_hsize     = m_hsize[3*i +: 3];
        m_hready[i] = s_hreadyout;
      end else begin
        m_hready[i] = ~req[i];
      end
      if (d_own_cur == IW'(i)) begin
        s_hwdata   = m_hwdata[64*i +: 64];
        m_hresp[i] = s_hresp & d_val_cur;
      end
    end
  end

  assign s_hsel   = s_htrans[1];
  assign s_hready = s_hreadyout;
  assign m_hrdata = s_hrdata;
endmodule
